// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for NUM_DIGITS common-anode 7-segment digits on a shared segment bus.
// Latches a hex value on a load strobe and scans digits round-robin with dead-time, blink and leading-zero blanking.
module seg7_scan_driver #(
    parameter int NUM_DIGITS       = 4,
    parameter int REFRESH_DIV      = 50000,
    parameter int DEAD_CYCLES      = 8,
    parameter int BLINK_FRAMES     = 64,
    parameter int ANODE_ACTIVE_LOW = 1,
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic [NUM_DIGITS-1:0]   blink_in,
    input  logic                    lz_blank,
    output logic [7:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic [IW-1:0]           digit_idx,
    output logic                    frame_tick
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] DEAD_END = PW'(DEAD_CYCLES);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_FRAMES - 1);
    localparam logic [NUM_DIGITS-1:0] AN_OFF =
        (ANODE_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    // Segment order [0]A [1]F [2]B [3]G [4]E [5]D [6]C [7]DP, active low, DP off
    function automatic logic [7:0] hex_to_seg(input logic [3:0] hex);
        logic [7:0] seg;
        case (hex)
            4'h0: seg = 8'h88;
            4'h1: seg = 8'hBB;
            4'h2: seg = 8'hC2;
            4'h3: seg = 8'h92;
            4'h4: seg = 8'hB1;
            4'h5: seg = 8'h94;
            4'h6: seg = 8'h84;
            4'h7: seg = 8'hB8;
            4'h8: seg = 8'h80;
            4'h9: seg = 8'h90;
            4'hA: seg = 8'hA0;
            4'hB: seg = 8'h85;
            4'hC: seg = 8'hCC;
            4'hD: seg = 8'h83;
            4'hE: seg = 8'hC4;
            4'hF: seg = 8'hE4;
            default: seg = 8'hFF;
        endcase
        return seg;
    endfunction

    logic [4*NUM_DIGITS-1:0] value_r;
    logic [NUM_DIGITS-1:0]   dp_r;
    logic [NUM_DIGITS-1:0]   blank_r;
    logic [NUM_DIGITS-1:0]   blink_r;
    logic [PW-1:0]           pre_r;
    logic [IW-1:0]           idx_r;
    logic [BW-1:0]           blk_cnt_r;
    logic                    blink_phase_r;

    logic                    slot_end_s;
    logic                    frame_end_s;
    logic                    zero_run_s;
    logic [NUM_DIGITS-1:0]   lz_s;
    logic [NUM_DIGITS-1:0]   onehot_s;
    logic [3:0]              nib_s;
    logic [7:0]              dec_s;
    logic                    dark_s;
    logic [7:0]              seg_next_s;
    logic [NUM_DIGITS-1:0]   an_next_s;

    assign slot_end_s  = enable & (pre_r == PRE_LAST);
    assign frame_end_s = slot_end_s & (idx_r == IDX_LAST);
    assign digit_idx   = idx_r;

    // Leading-zero mask: digit k is suppressed when it and every digit above it are zero
    always_comb begin
        zero_run_s = 1'b1;
        lz_s       = {NUM_DIGITS{1'b0}};
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_run_s = zero_run_s & (value_r[4*k +: 4] == 4'h0);
            lz_s[k]    = zero_run_s & lz_blank;
        end
        lz_s[0] = 1'b0;
    end

    // Next-cycle segment and anode pattern for the digit currently in its slot
    always_comb begin
        onehot_s = {NUM_DIGITS{1'b0}};
        for (int k = 0; k < NUM_DIGITS; k++) begin
            onehot_s[k] = (idx_r == IW'(k));
        end
        nib_s  = value_r[{idx_r, 2'b00} +: 4];
        dec_s  = hex_to_seg(nib_s);
        dark_s = ~enable | (pre_r < DEAD_END) | blank_r[idx_r]
               | (blink_r[idx_r] & blink_phase_r) | lz_s[idx_r];
        if (dark_s) begin
            seg_next_s = 8'hFF;
            an_next_s  = AN_OFF;
        end else begin
            seg_next_s = {dec_s[7] & ~dp_r[idx_r], dec_s[6:0]};
            an_next_s  = AN_OFF ^ onehot_s;
        end
    end

    // Shadow registers capture display data on the load strobe, regardless of enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_r <= {(4*NUM_DIGITS){1'b0}};
            dp_r    <= {NUM_DIGITS{1'b0}};
            blank_r <= {NUM_DIGITS{1'b0}};
            blink_r <= {NUM_DIGITS{1'b0}};
        end else if (load) begin
            value_r <= value_in;
            dp_r    <= dp_in;
            blank_r <= blank_in;
            blink_r <= blink_in;
        end
    end

    // Scan timing: prescaler, digit index, blink frame counter and phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_r         <= {PW{1'b0}};
            idx_r         <= {IW{1'b0}};
            blk_cnt_r     <= {BW{1'b0}};
            blink_phase_r <= 1'b0;
        end else if (enable) begin
            pre_r <= slot_end_s ? {PW{1'b0}} : pre_r + 1'b1;
            if (slot_end_s) begin
                idx_r <= (idx_r == IDX_LAST) ? {IW{1'b0}} : idx_r + 1'b1;
            end
            if (frame_end_s) begin
                if (blk_cnt_r == BLK_LAST) begin
                    blk_cnt_r     <= {BW{1'b0}};
                    blink_phase_r <= ~blink_phase_r;
                end else begin
                    blk_cnt_r <= blk_cnt_r + 1'b1;
                end
            end
        end
    end

    // Registered pin drivers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_out    <= 8'hFF;
            an_out     <= AN_OFF;
            frame_tick <= 1'b0;
        end else begin
            seg_out    <= seg_next_s;
            an_out     <= an_next_s;
            frame_tick <= frame_end_s;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: a cycle model pushes expected pin states to a queue
// at each drive step; they are popped and compared one cycle later, plus spec-table spot checks.
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        load;
    logic [15:0] value_in;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic [3:0]  blink_in;
    logic        lz_blank;
    logic [7:0]  seg_out;
    logic [3:0]  an_out;
    logic [1:0]  digit_idx;
    logic        frame_tick;

    int total = 0;
    int bad   = 0;

    seg7_scan_driver #(
        .NUM_DIGITS(4), .REFRESH_DIV(4), .DEAD_CYCLES(1),
        .BLINK_FRAMES(2), .ANODE_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .load(load),
        .value_in(value_in), .dp_in(dp_in), .blank_in(blank_in),
        .blink_in(blink_in), .lz_blank(lz_blank), .seg_out(seg_out),
        .an_out(an_out), .digit_idx(digit_idx), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    // reference model state
    int          m_pre, m_idx, m_bcnt;
    logic        m_phase;
    logic [15:0] m_val;
    logic [3:0]  m_dp, m_blank, m_blink;
    logic [14:0] exp_q[$];

    // observations within the current frame
    logic [7:0]  seg_seen[4];
    logic [3:0]  seen_lit;
    int          ticks;

    function automatic logic [7:0] ref_dec(input logic [3:0] h);
        logic [7:0] t[16] = '{8'h88, 8'hBB, 8'hC2, 8'h92, 8'hB1, 8'h94, 8'h84, 8'hB8,
                              8'h80, 8'h90, 8'hA0, 8'h85, 8'hCC, 8'h83, 8'hC4, 8'hE4};
        return t[h];
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pre = 0; m_idx = 0; m_bcnt = 0; m_phase = 1'b0;
        m_val = 16'h0000; m_dp = 4'h0; m_blank = 4'h0; m_blink = 4'h0;
    endtask

    task automatic clear_seen();
        seen_lit = 4'b0000;
        for (int k = 0; k < 4; k++) seg_seen[k] = 8'h00;
    endtask

    // one clock: predict outputs, push, advance model, clock, pop and compare
    task automatic step();
        logic       dark, lz, et;
        logic [3:0] ea;
        logic [7:0] es;
        lz   = lz_blank && (m_idx > 0) && ((m_val >> (4 * m_idx)) == 16'h0000);
        dark = !enable || (m_pre < 1) || m_blank[m_idx] || (m_blink[m_idx] && m_phase) || lz;
        if (dark) begin
            ea = 4'hF;
            es = 8'hFF;
        end else begin
            ea = ~(4'b0001 << m_idx);
            es = ref_dec(m_val[m_idx*4 +: 4]) & (m_dp[m_idx] ? 8'h7F : 8'hFF);
        end
        et = enable && (m_pre == 3) && (m_idx == 3);
        if (load) begin
            m_val = value_in; m_dp = dp_in; m_blank = blank_in; m_blink = blink_in;
        end
        if (enable) begin
            if (m_pre == 3) begin
                m_pre = 0;
                if (m_idx == 3) begin
                    m_idx = 0;
                    if (m_bcnt == 1) begin
                        m_bcnt = 0;
                        m_phase = !m_phase;
                    end else begin
                        m_bcnt++;
                    end
                end else begin
                    m_idx++;
                end
            end else begin
                m_pre++;
            end
        end
        exp_q.push_back({ea, es, 2'(m_idx), et});
        @(posedge clk);
        #1;
        begin
            logic [14:0] e;
            e = exp_q.pop_front();
            total++;
            assert ({an_out, seg_out, digit_idx, frame_tick} === e) else begin
                bad++;
                $error("FAIL cycle an/seg/idx/tick observed=%h expected=%h",
                       {an_out, seg_out, digit_idx, frame_tick}, e);
            end
        end
        for (int k = 0; k < 4; k++) begin
            if (an_out[k] == 1'b0) begin
                seen_lit[k] = 1'b1;
                seg_seen[k] = seg_out;
            end
        end
        if (frame_tick) ticks++;
    endtask

    task automatic run_frame(input bit do_load);
        clear_seen();
        for (int s = 0; s < 16; s++) begin
            load = do_load && (s == 0);
            step();
        end
        load = 1'b0;
    endtask

    initial begin
        logic [5:0] lit0, lit1;
        int guard;
        rst_n = 1'b0; enable = 1'b0; load = 1'b0; value_in = 16'h0000;
        dp_in = 4'h0; blank_in = 4'h0; blink_in = 4'h0; lz_blank = 1'b0;
        ticks = 0;
        clear_seen();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_seg", 16'(seg_out), 16'h00FF);
        chk("reset_an", 16'(an_out), 16'h000F);
        chk("reset_idx", 16'(digit_idx), 16'h0000);
        chk("reset_tick", 16'(frame_tick), 16'h0000);
        model_reset();
        rst_n = 1'b1;

        // 1234 with digit 0 blinking, six frames from a fresh scan
        enable = 1'b1; value_in = 16'h1234; blink_in = 4'b0001;
        for (int f = 0; f < 6; f++) begin
            run_frame(f == 0);
            lit0[f] = seen_lit[0];
            lit1[f] = seen_lit[1];
            if (f == 0) begin
                chk("dec_idx0", 16'(seg_seen[0]), 16'h00B1);
                chk("dec_idx1", 16'(seg_seen[1]), 16'h0092);
                chk("dec_idx2", 16'(seg_seen[2]), 16'h00C2);
                chk("dec_idx3", 16'(seg_seen[3]), 16'h00BB);
            end
        end
        chk("blink_digit0", 16'(lit0), 16'h0033);
        chk("blink_digit1", 16'(lit1), 16'h003F);
        chk("frame_ticks", 16'(ticks), 16'd6);

        // decimal point on digit 1
        blink_in = 4'b0000; dp_in = 4'b0010;
        run_frame(1'b1);
        chk("dp_idx1", 16'(seg_seen[1]), 16'h0012);
        chk("dp_idx0", 16'(seg_seen[0]), 16'h00B1);
        chk("dp_idx3", 16'(seg_seen[3]), 16'h00BB);

        // leading-zero suppression
        dp_in = 4'b0000; lz_blank = 1'b1; value_in = 16'h0070;
        run_frame(1'b1);
        chk("lz_lit", 16'(seen_lit), 16'h0003);
        chk("lz_idx1", 16'(seg_seen[1]), 16'h00B8);
        chk("lz_idx0", 16'(seg_seen[0]), 16'h0088);
        value_in = 16'h0000;
        run_frame(1'b1);
        chk("lz_zero_lit", 16'(seen_lit), 16'h0001);
        chk("lz_zero_idx0", 16'(seg_seen[0]), 16'h0088);

        // enable low: dark, frozen, load still captures
        lz_blank = 1'b0; enable = 1'b0; value_in = 16'hABCD; blank_in = 4'b0100;
        clear_seen();
        for (int s = 0; s < 6; s++) begin
            load = (s == 2);
            step();
        end
        load = 1'b0;
        chk("en0_dark", 16'(seen_lit), 16'h0000);
        enable = 1'b1; blank_in = 4'b0000;
        for (int s = 0; s < 6; s++) step();
        // load landing on a slot boundary
        guard = 0;
        while (m_pre != 3 && guard < 8) begin
            step();
            guard++;
        end
        value_in = 16'h5678; load = 1'b1;
        step();
        load = 1'b0;
        for (int s = 0; s < 12; s++) step();

        // asynchronous reset in the middle of digit 2's slot
        guard = 0;
        while (!(m_idx == 2 && m_pre == 2) && guard < 64) begin
            step();
            guard++;
        end
        chk("reach_idx2", 16'(guard < 64), 16'h0001);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_an", 16'(an_out), 16'h000F);
        chk("midrst_seg", 16'(seg_out), 16'h00FF);
        chk("midrst_idx", 16'(digit_idx), 16'h0000);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_frame(1'b0);
        chk("cleared_lit", 16'(seen_lit), 16'h000F);
        chk("cleared_idx0", 16'(seg_seen[0]), 16'h0088);
        chk("cleared_idx3", 16'(seg_seen[3]), 16'h0088);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
